window_stream_controller: RTL and testbench
===========================================

Name: window_stream_controller

Overview:
- Synthesizable controller that turns a nucleotide stream (reference or read) into overlapping windows.
- Drives the window_hasher, hash_table and stats handshakes: hasher reset, ready_for_hashing, is_insert/is_query, calculate_matched_window.
- Adds parametrised stride, window-count limits, backpressure, overflow detection and a registered match result.
- Sits between the sequence source (DMA/file model) and window_hasher / hash_table / stats.

Parameters:
- WINDOW_SIZE, 128, bases per window.
- KMER_SIZE, 16, k-mer length.
- STRIDE, WINDOW_SIZE-KMER_SIZE+1, base offset between consecutive window starts. Legal range 1..WINDOW_SIZE.
- MAX_WINDOWS_IN_REFERENCE, 512, window limit in reference mode.
- MAX_WINDOWS_IN_READ, 16, window limit in read mode.
- COMMIT_CYCLES, 2, cycles is_insert/is_query is held high.
- CTRL_RESET_CYCLES, 2, cycles reset_window_hasher/reset_stats are held high.
- CALC_CYCLES, 2, cycles calculate_matched_window is held high.

Ports:
- clk  in  1  clock.
- reset_window_controller  in  1  synchronous, active-high reset.
- start  in  1  begin a stream; sampled only in IDLE.
- is_reference  in  1  mode latched on start: 1 = insert, 0 = query.
- base_valid  in  1  base is valid.
- base  in  2  A=00, C=01, G=10, T=11.
- base_last  in  1  final base of the stream.
- base_ready  out  1  controller accepts a base.
- window  out  2 x WINDOW_SIZE  window[0] is the oldest base.
- window_id  out  32  index of the current window.
- reset_window_hasher  out  1  hasher reset pulse.
- ready_for_hashing  out  1  window stable, start hashing.
- hashing_is_done  in  1  from window_hasher.
- is_insert  out  1  to hash_table.
- is_query  out  1  to hash_table and stats.
- reset_stats  out  1  to stats.
- calculate_matched_window  out  1  to stats.
- matched_window_id  in  32 signed  from stats.
- result_window_id  out  32 signed  captured match; -1 means none.
- result_valid  out  1  one-cycle pulse.
- overflow  out  1  sticky window-limit flag; cleared on start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of stream.

Behaviour:
- Reset: all outputs 0, except result_window_id = -1. Window contents = 0. State IDLE. A reset asserted mid-operation aborts the stream with no done or result_valid pulse.
- States: IDLE, INIT, FILL, HRST, HASH, COMMIT, FINISH, CALC.
- IDLE: start=1 latches mode, clears window_id, fill count, last_seen and overflow, then enters INIT. start is ignored in all other states.
- INIT: reset_stats and reset_window_hasher high for CTRL_RESET_CYCLES, then FILL.
- FILL:
  - base_ready=1 (also in the drop case below).
  - On each base_valid&&base_ready, the window shifts down and the base enters window[WINDOW_SIZE-1]; fill increments.
  - Target is WINDOW_SIZE for window 0 and STRIDE thereafter. The last KMER_SIZE-1 bases are retained automatically by the shift.
  - Fill reaching target on a beat → HRST on the next cycle.
  - base_last on a beat sets last_seen. If the target is also reached on that beat, the window is processed. Otherwise the partial window is discarded and the state goes to FINISH.
- HRST: reset_window_hasher high for CTRL_RESET_CYCLES, then HASH.
- HASH: ready_for_hashing=1 until hashing_is_done is sampled high, then COMMIT. No timeout.
- COMMIT:
  - is_insert (reference mode) or is_query (read mode) high for exactly COMMIT_CYCLES; window_id is held stable throughout.
  - On exit, window_id increments and fill clears.
  - Next state is FINISH if last_seen, otherwise FILL.
- Window limit:
  - If window_id+1 equals the mode limit at COMMIT exit and last_seen=0, set overflow.
  - Remain in FILL with base_ready=1, dropping bases without shifting, until base_last, then FINISH.
- FINISH:
  - Reference mode: done pulse, then IDLE.
  - Read mode: go to CALC.
- CALC: calculate_matched_window high for CALC_CYCLES. On the last cycle, capture matched_window_id into result_window_id and pulse result_valid and done together, then IDLE.
- A stream with zero complete windows still runs CALC in read mode.
- base_ready=0 in every state except FILL, so window is stable whenever ready_for_hashing=1.
- window_id saturates at 2^32-1. This is unreachable under the legal limits.

Decomposition:
- Shared package lsh_pkg holds:
  - nucleotide_t (2-bit enum A/C/G/T);
  - ctrl_state_t enum;
  - localparam NO_MATCH = -1;
  - the window array typedef shared with window_hasher.
- One sub-module, window_shift_buffer: WINDOW_SIZE x 2-bit shift register with shift enable and synchronous clear, exposing the full window.

Test Plan:
- Reference mode, WINDOW_SIZE=8, KMER_SIZE=4 (STRIDE=5), 18 bases → 3 windows with ids 0,1,2. Each gets one 2-cycle is_insert; window 1 equals bases 5..12. Then a done pulse, with no calculate_matched_window.
- Read mode, same parameters, 12 bases, stats returns 7 → one is_query for window 0; the 4-base remainder is discarded. calculate_matched_window is held 2 cycles, then result_window_id=7 with result_valid and done.
- Read mode, 5 bases, stats returns -1 → no is_query; CALC runs; result_window_id=-1.
- Read mode, MAX_WINDOWS_IN_READ=2, 40 bases → exactly 2 queries and overflow=1. All remaining bases are accepted and dropped; done after base_last.
- hashing_is_done delayed 20 cycles and base_valid held high → ready_for_hashing holds for 20 cycles with base_ready=0 and window unchanged throughout.
- reset_window_controller asserted during HASH → next cycle all outputs are at reset values and the state is IDLE. A following start processes a fresh stream from window_id 0.

Source files
------------

// File: rtl/lsh_pkg.sv
// Shared types for the LSH pipeline: nucleotide encoding, controller states
// and the window array used by window_stream_controller and window_hasher.
package lsh_pkg;

  typedef enum logic [1:0] {
    NUC_A = 2'b00,
    NUC_C = 2'b01,
    NUC_G = 2'b10,
    NUC_T = 2'b11
  } nucleotide_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_FILL,
    ST_HRST,
    ST_HASH,
    ST_COMMIT,
    ST_FINISH,
    ST_CALC
  } ctrl_state_t;

  localparam logic signed [31:0] NO_MATCH = -32'sd1;

  // Default-size window as seen by window_hasher; element 0 is the oldest base.
  localparam int LSH_WINDOW_SIZE = 128;
  typedef logic [LSH_WINDOW_SIZE-1:0][1:0] window_t;

endpackage

// File: rtl/window_shift_buffer.sv
// WINDOW_SIZE x 2-bit shift register: new bases enter at the top element,
// older bases move toward element 0.
import lsh_pkg::*;

module window_shift_buffer #(
  parameter int WINDOW_SIZE = 128
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        shift_en,
  input  nucleotide_t                 base_in,
  output logic [WINDOW_SIZE-1:0][1:0] window
);

  always_ff @(posedge clk) begin
    if (clear) begin
      window <= '0;
    end else if (shift_en) begin
      window <= {base_in, window[WINDOW_SIZE-1:1]};
    end
  end

endmodule

// File: rtl/window_stream_controller.sv
// Turns a nucleotide stream into overlapping windows and sequences the
// hasher, hash_table and stats handshakes for each window.
import lsh_pkg::*;

module window_stream_controller #(
  parameter int WINDOW_SIZE              = 128,
  parameter int KMER_SIZE                = 16,
  parameter int STRIDE                   = WINDOW_SIZE - KMER_SIZE + 1,
  parameter int MAX_WINDOWS_IN_REFERENCE = 512,
  parameter int MAX_WINDOWS_IN_READ      = 16,
  parameter int COMMIT_CYCLES            = 2,
  parameter int CTRL_RESET_CYCLES        = 2,
  parameter int CALC_CYCLES              = 2
) (
  input  logic                        clk,
  input  logic                        reset_window_controller,
  input  logic                        start,
  input  logic                        is_reference,
  input  logic                        base_valid,
  input  logic [1:0]                  base,
  input  logic                        base_last,
  output logic                        base_ready,
  output logic [WINDOW_SIZE-1:0][1:0] window,
  output logic [31:0]                 window_id,
  output logic                        reset_window_hasher,
  output logic                        ready_for_hashing,
  input  logic                        hashing_is_done,
  output logic                        is_insert,
  output logic                        is_query,
  output logic                        reset_stats,
  output logic                        calculate_matched_window,
  input  logic signed [31:0]          matched_window_id,
  output logic signed [31:0]          result_window_id,
  output logic                        result_valid,
  output logic                        overflow,
  output logic                        busy,
  output logic                        done
);

  localparam int FILL_W = $clog2(WINDOW_SIZE + 1);

  if (STRIDE < 1 || STRIDE > WINDOW_SIZE || KMER_SIZE < 1 || KMER_SIZE > WINDOW_SIZE) begin : g_bad_params
    $error("window_stream_controller: illegal STRIDE/KMER_SIZE for WINDOW_SIZE");
  end

  ctrl_state_t        state, next_state;
  logic               mode_ref;
  logic               last_seen;
  logic [FILL_W-1:0]  fill_cnt;
  logic [FILL_W-1:0]  fill_target;
  logic [15:0]        phase_cnt;
  logic               phase_last;
  logic               beat;
  logic               fill_hit;
  logic               limit_hit;
  logic [31:0]        mode_limit;

  assign beat        = base_valid && base_ready;
  // Window 0 needs a full load; later windows only need STRIDE new bases.
  assign fill_target = (window_id == 32'd0) ? FILL_W'(WINDOW_SIZE) : FILL_W'(STRIDE);
  assign fill_hit    = !overflow && ((fill_cnt + 1'b1) == fill_target);
  assign mode_limit  = mode_ref ? 32'(MAX_WINDOWS_IN_REFERENCE) : 32'(MAX_WINDOWS_IN_READ);
  assign limit_hit   = (window_id + 32'd1) == mode_limit;

  window_shift_buffer #(
    .WINDOW_SIZE (WINDOW_SIZE)
  ) u_shift_buffer (
    .clk      (clk),
    .clear    (reset_window_controller),
    .shift_en (beat && !overflow),
    .base_in  (nucleotide_t'(base)),
    .window   (window)
  );

  always_ff @(posedge clk) begin
    if (reset_window_controller) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Shared dwell counter for the fixed-length pulse states.
  always_ff @(posedge clk) begin
    if (reset_window_controller || (next_state != state)) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + 16'd1;
    end
  end

  always_comb begin
    phase_last = 1'b0;
    case (state)
      ST_INIT, ST_HRST: phase_last = (phase_cnt == 16'(CTRL_RESET_CYCLES - 1));
      ST_COMMIT:        phase_last = (phase_cnt == 16'(COMMIT_CYCLES - 1));
      ST_CALC:          phase_last = (phase_cnt == 16'(CALC_CYCLES - 1));
      default:          phase_last = 1'b0;
    endcase
  end

  always_comb begin
    next_state               = state;
    base_ready               = 1'b0;
    reset_window_hasher      = 1'b0;
    reset_stats              = 1'b0;
    ready_for_hashing        = 1'b0;
    is_insert                = 1'b0;
    is_query                 = 1'b0;
    calculate_matched_window = 1'b0;
    busy                     = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (start) next_state = ST_INIT;
      ST_INIT: begin
        reset_stats         = 1'b1;
        reset_window_hasher = 1'b1;
        if (phase_last) next_state = ST_FILL;
      end
      ST_FILL: begin
        base_ready = 1'b1;
        // After overflow, bases are swallowed until the stream ends.
        if (beat) begin
          if (fill_hit)       next_state = ST_HRST;
          else if (base_last) next_state = ST_FINISH;
        end
      end
      ST_HRST: begin
        reset_window_hasher = 1'b1;
        if (phase_last) next_state = ST_HASH;
      end
      ST_HASH: begin
        ready_for_hashing = 1'b1;
        if (hashing_is_done) next_state = ST_COMMIT;
      end
      ST_COMMIT: begin
        is_insert = mode_ref;
        is_query  = !mode_ref;
        if (phase_last) next_state = last_seen ? ST_FINISH : ST_FILL;
      end
      ST_FINISH: next_state = mode_ref ? ST_IDLE : ST_CALC;
      ST_CALC: begin
        calculate_matched_window = 1'b1;
        if (phase_last) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_window_controller) begin
      mode_ref         <= 1'b0;
      last_seen        <= 1'b0;
      fill_cnt         <= '0;
      window_id        <= '0;
      overflow         <= 1'b0;
      done             <= 1'b0;
      result_valid     <= 1'b0;
      result_window_id <= NO_MATCH;
    end else begin
      done         <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_ref  <= is_reference;
            last_seen <= 1'b0;
            fill_cnt  <= '0;
            window_id <= '0;
            overflow  <= 1'b0;
          end
        end
        ST_FILL: begin
          if (beat) begin
            if (!overflow) fill_cnt <= fill_cnt + 1'b1;
            if (base_last) last_seen <= 1'b1;
          end
        end
        ST_COMMIT: begin
          if (phase_last) begin
            fill_cnt <= '0;
            if (window_id != 32'hFFFF_FFFF) window_id <= window_id + 32'd1;
            if (limit_hit && !last_seen) overflow <= 1'b1;
          end
        end
        ST_FINISH: if (mode_ref) done <= 1'b1;
        ST_CALC: begin
          if (phase_last) begin
            result_window_id <= matched_window_id;
            result_valid     <= 1'b1;
            done             <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_window_stream_controller.sv
// Self-checking bench: a window-level model predicts contents, ids, pulse
// lengths, overflow and result for each stream; a monitor compares every cycle.
module tb_window_stream_controller;

  localparam int W     = 8;
  localparam int K     = 4;
  localparam int S     = W - K + 1;
  localparam int LREF  = 512;
  localparam int LREAD = 2;

  logic                clk = 1'b0;
  logic                reset_window_controller;
  logic                start;
  logic                is_reference;
  logic                base_valid;
  logic [1:0]          base;
  logic                base_last;
  logic                base_ready;
  logic [W-1:0][1:0]   window;
  logic [31:0]         window_id;
  logic                reset_window_hasher;
  logic                ready_for_hashing;
  logic                hashing_is_done;
  logic                is_insert;
  logic                is_query;
  logic                reset_stats;
  logic                calculate_matched_window;
  logic signed [31:0]  matched_window_id;
  logic signed [31:0]  result_window_id;
  logic                result_valid;
  logic                overflow;
  logic                busy;
  logic                done;

  window_stream_controller #(
    .WINDOW_SIZE              (W),
    .KMER_SIZE                (K),
    .MAX_WINDOWS_IN_REFERENCE (LREF),
    .MAX_WINDOWS_IN_READ      (LREAD)
  ) dut (
    .clk                      (clk),
    .reset_window_controller  (reset_window_controller),
    .start                    (start),
    .is_reference             (is_reference),
    .base_valid               (base_valid),
    .base                     (base),
    .base_last                (base_last),
    .base_ready               (base_ready),
    .window                   (window),
    .window_id                (window_id),
    .reset_window_hasher      (reset_window_hasher),
    .ready_for_hashing        (ready_for_hashing),
    .hashing_is_done          (hashing_is_done),
    .is_insert                (is_insert),
    .is_query                 (is_query),
    .reset_stats              (reset_stats),
    .calculate_matched_window (calculate_matched_window),
    .matched_window_id        (matched_window_id),
    .result_window_id         (result_window_id),
    .result_valid             (result_valid),
    .overflow                 (overflow),
    .busy                     (busy),
    .done                     (done)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [1:0] seq [64];
  bit         cur_mode;
  int         hash_delay = 3;
  int         exp_count;
  bit         exp_ovf;
  bit         test_active = 1'b0;
  bit         done_seen;
  int         commits_seen, ready_run, commit_run, calc_run;
  logic [15:0] w1_capture;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic logic [15:0] expWindow(input int id);
    logic [W-1:0][1:0] w;
    for (int j = 0; j < W; j++) w[j] = seq[(id * S + j) % 64];
    return w;
  endfunction

  // Window-hasher stand-in: raises hashing_is_done after hash_delay cycles of ready.
  initial begin
    int hcnt;
    hcnt = 0;
    hashing_is_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_for_hashing) begin
        hcnt++;
        hashing_is_done = (hcnt >= hash_delay);
      end else begin
        hcnt = 0;
        hashing_is_done = 1'b0;
      end
    end
  end

  // Per-cycle monitor against the window-level model.
  initial begin
    forever begin
      @(negedge clk);
      if (test_active) begin
        if (ready_for_hashing) begin
          checkOutput("hash_base_ready", base_ready, 0);
          checkOutput("hash_window_id", window_id, commits_seen);
          checkOutput("hash_window", window, expWindow(commits_seen));
          ready_run++;
        end else if (ready_run > 0) begin
          checkOutput("ready_len", ready_run, hash_delay);
          ready_run = 0;
        end
        if (is_insert || is_query) begin
          checkOutput("commit_kind", {is_insert, is_query}, {cur_mode, !cur_mode});
          checkOutput("commit_window_id", window_id, commits_seen);
          checkOutput("commit_in_range", commits_seen < exp_count, 1);
          checkOutput("commit_window", window, expWindow(commits_seen));
          if (commits_seen == 1 && commit_run == 0) w1_capture = window;
          commit_run++;
        end else if (commit_run > 0) begin
          checkOutput("commit_len", commit_run, 2);
          commits_seen++;
          commit_run = 0;
        end
        if (calculate_matched_window) calc_run++;
        if (done) begin
          checkOutput("done_windows", commits_seen, exp_count);
          checkOutput("done_calc_len", calc_run, cur_mode ? 0 : 2);
          checkOutput("done_result_valid", result_valid, !cur_mode);
          if (!cur_mode) checkOutput("done_result", {32'b0, result_window_id}, {32'b0, matched_window_id});
          checkOutput("done_overflow", overflow, exp_ovf);
          done_seen = 1'b1;
        end
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_base_ready"}, base_ready, 0);
    checkOutput({tag, "_window"}, window, 0);
    checkOutput({tag, "_window_id"}, window_id, 0);
    checkOutput({tag, "_ctrl"}, {reset_window_hasher, ready_for_hashing, is_insert, is_query,
                                 reset_stats, calculate_matched_window}, 0);
    checkOutput({tag, "_result"}, {32'b0, result_window_id}, {32'b0, 32'hFFFF_FFFF});
    checkOutput({tag, "_pulses"}, {result_valid, overflow, done}, 0);
  endtask

  task automatic applyStimulus(input bit ref_mode, input int n, input int delay,
                               input logic signed [31:0] matched, input bit stop_at_hash);
    int  i, guard, full, limit;
    bit  accepted;
    cur_mode          = ref_mode;
    hash_delay        = delay;
    matched_window_id = matched;
    for (int k = 0; k < 64; k++) seq[k] = 2'((k + k / 4) % 4);
    limit        = ref_mode ? LREF : LREAD;
    full         = (n >= W) ? (n - W) / S + 1 : 0;
    exp_count    = (full < limit) ? full : limit;
    exp_ovf      = (full >= limit) && ((limit - 1) * S + W < n);
    commits_seen = 0; ready_run = 0; commit_run = 0; calc_run = 0;
    done_seen    = 1'b0;
    test_active  = !stop_at_hash;
    @(negedge clk);
    start = 1'b1; is_reference = ref_mode;
    @(negedge clk);
    start = 1'b0;
    i = 0; guard = 0;
    while (i < n && guard < 3000 && !(stop_at_hash && ready_for_hashing)) begin
      base_valid = 1'b1; base = seq[i]; base_last = (i == n - 1);
      accepted = base_ready;
      @(posedge clk);
      guard++;
      if (accepted) i++;
      @(negedge clk);
    end
    base_valid = 1'b0; base_last = 1'b0;
    checkOutput("feed_within_bound", guard < 3000, 1);
    if (!stop_at_hash) begin
      guard = 0;
      while (!done_seen && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      checkOutput("done_seen", done_seen, 1);
      @(negedge clk);
      checkOutput("done_one_cycle", {done, result_valid, busy}, 0);
      test_active = 1'b0;
    end
  endtask

  initial begin
    reset_window_controller = 1'b1;
    start = 1'b0; is_reference = 1'b0;
    base_valid = 1'b0; base = 2'b00; base_last = 1'b0;
    matched_window_id = 32'sd0;
    repeat (2) @(negedge clk);
    checkResetValues("por");
    reset_window_controller = 1'b0;

    $display("[TB] reference stream, 18 bases");
    applyStimulus(1'b1, 18, 3, 32'sd0, 1'b0);
    checkOutput("ref_windows_literal", commits_seen, 3);
    checkOutput("ref_window1_literal", w1_capture, 16'hD38E);

    $display("[TB] read stream, 12 bases, match 7");
    applyStimulus(1'b0, 12, 3, 32'sd7, 1'b0);
    checkOutput("read_windows_literal", commits_seen, 1);
    checkOutput("read_result_literal", {32'b0, result_window_id}, 64'd7);

    $display("[TB] reset during HASH");
    applyStimulus(1'b1, 18, 1000, 32'sd0, 1'b1);
    checkOutput("abort_in_hash", ready_for_hashing, 1);
    reset_window_controller = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_window_controller = 1'b0;
    checkResetValues("abort");

    $display("[TB] read stream, 5 bases, no match");
    applyStimulus(1'b0, 5, 3, -32'sd1, 1'b0);
    checkOutput("short_windows_literal", commits_seen, 0);
    checkOutput("short_result_literal", {32'b0, result_window_id}, {32'b0, 32'hFFFF_FFFF});

    $display("[TB] read stream, 40 bases, limit 2");
    applyStimulus(1'b0, 40, 3, 32'sd1, 1'b0);
    checkOutput("ovf_windows_literal", commits_seen, 2);
    checkOutput("ovf_flag_literal", overflow, 1);

    $display("[TB] reference stream, 13 bases, slow hasher");
    applyStimulus(1'b1, 13, 20, 32'sd0, 1'b0);
    checkOutput("slow_windows_literal", commits_seen, 2);
    checkOutput("slow_ovf_cleared", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
